// File: rtl/perf_counter_bank.sv
// perf_counter_bank: memory-mapped performance counters beside the MEM stage.
// The low address window holds NUM_CTRS counters followed by one CTRL word.
// Every other address is passed through to the data cache. Bank accesses
// complete with a one-cycle registered response pulse (ctr_resp).
module perf_counter_bank #(
    parameter int NUM_CTRS = 8,        // 1..16
    parameter int CTR_W    = 32,       // 1..32
    parameter bit SATURATE = 1'b0      // 0: wrap at max, 1: hold at max
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CTRS-1:0] event_inc,
    input  logic [31:0]         mem_address,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         mem_wdata,
    output logic                dcache_read,
    output logic                dcache_write,
    output logic                datamux_sel,
    output logic [31:0]         counter_data,
    output logic                ctr_resp
);

    // Window size in bytes: one word per counter plus the CTRL word.
    localparam logic [31:0] WIN      = 32'((NUM_CTRS + 1) * 4);
    // The window is at most 17 words, so a 5-bit word index covers it.
    localparam logic [4:0]  CTRL_IDX = 5'(NUM_CTRS);

    logic                w_hit;
    logic [4:0]          w_idx;
    logic                w_wr;
    logic                w_rd;
    logic                w_ctrl_wr;
    logic                w_clear_all;
    logic [NUM_CTRS-1:0] w_ctr_wr;
    logic [31:0]         w_rd_word;

    logic [CTR_W-1:0]    r_ctr [NUM_CTRS];
    logic [NUM_CTRS-1:0] r_ovf;
    logic                r_freeze;
    logic [31:0]         r_counter_data;
    logic                r_resp;

    // Address decode. The byte offset bits [1:0] are ignored.
    assign w_hit       = (mem_address < WIN);
    assign w_idx       = mem_address[6:2];
    // A simultaneous read+write is treated as a write.
    assign w_wr        = w_hit & mem_write;
    assign w_rd        = w_hit & mem_read & ~mem_write;
    assign w_ctrl_wr   = w_wr & (w_idx == CTRL_IDX);
    // clear_all is a strobe taken straight from the write data; it is never stored.
    assign w_clear_all = w_ctrl_wr & mem_wdata[1];

    // Route MEM-stage requests: bank hits never reach the data cache.
    always_comb begin
        dcache_read  = mem_read;
        dcache_write = mem_write;
        datamux_sel  = 1'b0;
        if (w_hit) begin
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
            datamux_sel  = 1'b1;
        end
    end

    // Freeze bit: loaded by any CTRL write, regardless of clear_all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_freeze <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_freeze <= mem_wdata[0];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
            assign w_ctr_wr[gi] = w_wr & (w_idx == 5'(gi));

            // Counter and sticky overflow: reset/clear, then software load, then event count.
            always_ff @(posedge clk) begin
                if (rst || w_clear_all) begin
                    r_ctr[gi] <= '0;
                    r_ovf[gi] <= 1'b0;
                end else if (w_ctr_wr[gi]) begin
                    // A same-cycle event is dropped; overflow history is kept.
                    r_ctr[gi] <= mem_wdata[CTR_W-1:0];
                end else if (event_inc[gi] && !r_freeze) begin
                    if (r_ctr[gi] == {CTR_W{1'b1}}) begin
                        r_ovf[gi] <= 1'b1;
                        if (!SATURATE) begin
                            r_ctr[gi] <= '0;
                        end
                    end else begin
                        r_ctr[gi] <= r_ctr[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Select the addressed word from pre-update state, zero-extended to 32 bits.
    always_comb begin
        w_rd_word = '0;
        if (w_idx == CTRL_IDX) begin
            w_rd_word[0]               = r_freeze;
            w_rd_word[16 +: NUM_CTRS]  = r_ovf;
        end else begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                if (w_idx == 5'(i)) begin
                    w_rd_word[CTR_W-1:0] = r_ctr[i];
                end
            end
        end
    end

    // Registered response: pulse for every bank access, data only captured on reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp         <= 1'b0;
            r_counter_data <= '0;
        end else begin
            r_resp <= w_wr | w_rd;
            if (w_rd) begin
                r_counter_data <= w_rd_word;
            end
        end
    end

    assign ctr_resp     = r_resp;
    assign counter_data = r_counter_data;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank. Three instances share one stimulus bus:
// inst 0 = 8 x 32-bit wrapping, inst 1 = 8 x 4-bit wrapping, inst 2 = 8 x 4-bit saturating.
// Read/write responses are expected via a scoreboard queue keyed by due cycle.
module tb_perf_counter_bank;

    logic        clk;
    logic        rst;
    logic [7:0]  event_inc;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;

    logic        dc_rd  [3];
    logic        dc_wr  [3];
    logic        sel    [3];
    logic        resp   [3];
    logic [31:0] cd     [3];

    perf_counter_bank #(.NUM_CTRS(8), .CTR_W(32), .SATURATE(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .event_inc(event_inc), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .dcache_read(dc_rd[0]), .dcache_write(dc_wr[0]), .datamux_sel(sel[0]),
        .counter_data(cd[0]), .ctr_resp(resp[0]));

    perf_counter_bank #(.NUM_CTRS(8), .CTR_W(4), .SATURATE(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .event_inc(event_inc), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .dcache_read(dc_rd[1]), .dcache_write(dc_wr[1]), .datamux_sel(sel[1]),
        .counter_data(cd[1]), .ctr_resp(resp[1]));

    perf_counter_bank #(.NUM_CTRS(8), .CTR_W(4), .SATURATE(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .event_inc(event_inc), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .dcache_read(dc_rd[2]), .dcache_write(dc_wr[2]), .datamux_sel(sel[2]),
        .counter_data(cd[2]), .ctr_resp(resp[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        bit          rd;
        bit          wr;
        logic [31:0] wdata;
        logic [7:0]  ev;
        int          reps;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    typedef struct {
        int          due;
        bit          is_rd;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        string       name;
    } sb_t;

    localparam logic [31:0] WIN_BYTES = 32'd36;

    vec_t        vecs [$];
    sb_t         sb   [$];
    logic [31:0] last_d [3];
    int          cyc;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input string name, input logic [31:0] addr, input bit rd, input bit wr,
                       input logic [31:0] wdata, input logic [7:0] ev, input int reps,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        vec_t v;
        v.name = name; v.addr = addr; v.rd = rd; v.wr = wr; v.wdata = wdata;
        v.ev = ev; v.reps = reps; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        vecs.push_back(v);
    endtask

    // Advance one clock and check the registered outputs against the scoreboard.
    task automatic tick();
        bit          rst_at_edge;
        bit          exp_resp;
        sb_t         e;
        rst_at_edge = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_at_edge) begin
            sb.delete();
            for (int k = 0; k < 3; k++) last_d[k] = '0;
        end
        exp_resp = (sb.size() > 0) && (sb[0].due == cyc);
        if (exp_resp) begin
            e = sb.pop_front();
            if (e.is_rd) begin
                last_d[0] = e.d0;
                last_d[1] = e.d1;
                last_d[2] = e.d2;
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_resp%0d", exp_resp ? e.name : "idle", k), {31'd0, resp[k]}, {31'd0, exp_resp});
            chk($sformatf("%s_data%0d", exp_resp ? e.name : "idle", k), cd[k], last_d[k]);
        end
        $display("[TB] cyc %0d resp=%0d data=%h/%h/%h", cyc, resp[0], cd[0], cd[1], cd[2]);
    endtask

    // Drive one cycle of MEM-stage stimulus, queue the expected response, check routing.
    task automatic drive(input string name, input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [31:0] wdata, input logic [7:0] ev,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        bit  hit;
        sb_t e;
        mem_address = addr;
        mem_read    = rd;
        mem_write   = wr;
        mem_wdata   = wdata;
        event_inc   = ev;
        hit = (addr < WIN_BYTES);
        if (!rst && hit && (rd || wr)) begin
            e.due = cyc + 1; e.is_rd = rd && !wr; e.d0 = d0; e.d1 = d1; e.d2 = d2; e.name = name;
            sb.push_back(e);
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_dcrd%0d", name, k), {31'd0, dc_rd[k]}, {31'd0, hit ? 1'b0 : rd});
            chk($sformatf("%s_dcwr%0d", name, k), {31'd0, dc_wr[k]}, {31'd0, hit ? 1'b0 : wr});
            chk($sformatf("%s_sel%0d",  name, k), {31'd0, sel[k]},   {31'd0, hit});
        end
        tick();
    endtask

    task automatic idle(input string name);
        drive(name, 32'h100, 1'b0, 1'b0, 32'd0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int k = 0; k < 3; k++) last_d[k] = '0;
        rst = 1'b1; event_inc = '0; mem_address = 32'h100;
        mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;

        // Expected data columns: inst0 (32b wrap), inst1 (4b wrap), inst2 (4b sat).
        add("t1_ev2",        32'h100, 0, 0, 32'h0,        8'h04, 5,  0, 0, 0);
        add("t1_rd2",        32'h008, 1, 0, 32'h0,        8'h00, 1,  5, 5, 5);
        add("t2_miss40",     32'h040, 1, 0, 32'h0,        8'h00, 1,  0, 0, 0);
        add("t2_miss24",     32'h024, 1, 0, 32'h0,        8'h00, 1,  0, 0, 0);
        add("t2_wmiss",      32'h1000,0, 1, 32'hDEAD,     8'h00, 1,  0, 0, 0);
        add("ctrl_lowbits",  32'h023, 1, 0, 32'h0,        8'h00, 1,  0, 0, 0);
        add("t3_ev0",        32'h100, 0, 0, 32'h0,        8'h01, 17, 0, 0, 0);
        add("t3_rd0",        32'h000, 1, 0, 32'h0,        8'h00, 1,  17, 1, 15);
        add("t3_ctrl",       32'h020, 1, 0, 32'h0,        8'h00, 1,  0, 32'h10000, 32'h10000);
        add("t5_wr1_ev",     32'h004, 0, 1, 32'h64,       8'h02, 1,  0, 0, 0);
        add("t5_rd1_ev",     32'h004, 1, 0, 32'h0,        8'h02, 1,  100, 4, 4);
        add("t5_rd1",        32'h004, 1, 0, 32'h0,        8'h00, 1,  101, 5, 5);
        add("wr0",           32'h000, 0, 1, 32'h3,        8'h00, 1,  0, 0, 0);
        add("ovf_kept",      32'h020, 1, 0, 32'h0,        8'h00, 1,  0, 32'h10000, 32'h10000);
        add("rd0_loaded",    32'h000, 1, 0, 32'h0,        8'h00, 1,  3, 3, 3);
        add("t4_freeze",     32'h020, 0, 1, 32'h1,        8'h00, 1,  0, 0, 0);
        add("t4_rd_ctrl",    32'h020, 1, 0, 32'h0,        8'h00, 1,  1, 32'h10001, 32'h10001);
        add("t4_ev_all",     32'h100, 0, 0, 32'h0,        8'hFF, 10, 0, 0, 0);
        add("t4_rd2",        32'h008, 1, 0, 32'h0,        8'h00, 1,  5, 5, 5);
        add("t4_rd1",        32'h004, 1, 0, 32'h0,        8'h00, 1,  101, 5, 5);
        add("rdwr_wr3",      32'h00C, 1, 1, 32'h7,        8'h08, 1,  0, 0, 0);
        add("rd3_after_rw",  32'h00C, 1, 0, 32'h0,        8'h00, 1,  7, 7, 7);
        add("t4_clear",      32'h020, 0, 1, 32'h2,        8'h00, 1,  0, 0, 0);
        add("clr_ctrl",      32'h020, 1, 0, 32'h0,        8'h00, 1,  0, 0, 0);
        add("clr_rd1",       32'h004, 1, 0, 32'h0,        8'h00, 1,  0, 0, 0);
        add("clr_rd0",       32'h000, 1, 0, 32'h0,        8'h00, 1,  0, 0, 0);
        add("wr3_max",       32'h00C, 0, 1, 32'hFFFFFFFF, 8'h00, 1,  0, 0, 0);
        add("ev3_at_max",    32'h100, 0, 0, 32'h0,        8'h08, 1,  0, 0, 0);
        add("rd3_wrap",      32'h00C, 1, 0, 32'h0,        8'h00, 1,  0, 0, 15);
        add("ctrl_ovf3",     32'h020, 1, 0, 32'h0,        8'h00, 1,  32'h80000, 32'h80000, 32'h80000);
        add("ev_all3",       32'h100, 0, 0, 32'h0,        8'hFF, 3,  0, 0, 0);
        add("rd7",           32'h01C, 1, 0, 32'h0,        8'h00, 1,  3, 3, 3);

        // Reset state.
        tick();
        tick();
        rst = 1'b0;

        foreach (vecs[v]) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                drive(vecs[v].name, vecs[v].addr, vecs[v].rd, vecs[v].wr, vecs[v].wdata,
                      vecs[v].ev, vecs[v].d0, vecs[v].d1, vecs[v].d2);
            end
        end

        // T6: read issued, reset in the following cycle drops everything.
        drive("t6_rd2", 32'h008, 1'b1, 1'b0, 32'h0, 8'h00, 3, 3, 3);
        rst = 1'b1;
        idle("t6_rst");
        // Read presented while reset is high gets no response.
        drive("t6_rd_in_rst", 32'h008, 1'b1, 1'b0, 32'h0, 8'h00, 0, 0, 0);
        rst = 1'b0;
        drive("t6_rd2_after", 32'h008, 1'b1, 1'b0, 32'h0, 8'h00, 0, 0, 0);
        drive("t6_rd7_after", 32'h01C, 1'b1, 1'b0, 32'h0, 8'h00, 0, 0, 0);
        drive("t6_ctrl_after", 32'h020, 1'b1, 1'b0, 32'h0, 8'h00, 0, 0, 0);
        idle("drain");

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
